// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit for the MIPS datapath.
//
// One 32-iteration shift-add multiply or restoring divide per start handshake.
// The 64-bit result lands in the architectural HI/LO registers. MTHI/MTLO
// writes also go through this block.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; aborts any operation in flight
//   start      operation request, accepted when idle or in the FIX cycle
//   operation  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operandA   multiplicand / dividend (rs)
//   operandB   multiplier / divisor (rt)
//   hiWrite    MTHI strobe, honoured only while idle
//   loWrite    MTLO strobe, honoured only while idle
//   writeData  MTHI/MTLO data
//   busy       operation in progress (RUN or FIX)
//   done       one-cycle pulse, hi/lo just updated by an operation
//   hi, lo     HI (product high / remainder), LO (product low / quotient)
module mdu (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  operation,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic        hiWrite,
   input  logic        loWrite,
   input  logic [31:0] writeData,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state, state_next;
   logic [4:0]  count;
   logic        op_div;
   logic        sign_a, sign_b;
   logic [31:0] raw_a;
   logic [31:0] mag_b;
   logic [63:0] acc;
   logic        accept;

   logic [32:0] mul_upper;
   logic [63:0] mul_next;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_rem;
   logic [63:0] div_next;
   logic [63:0] mul_res;
   logic [31:0] res_hi, res_lo;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

   // Magnitude of a signed operand; unsigned operands pass through.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? neg32(v) : v;
   endfunction

   assign busy   = (state != IDLE);
   // The FIX cycle also accepts start so a new op can begin on the edge that
   // writes the previous result.
   assign accept = start && (state == IDLE || state == FIX);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (count == 5'd31) state_next = FIX;
         FIX:     state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Multiply: acc = {partial product, remaining multiplier bits}; add the
   // multiplicand into the top half when the LSB is set, then shift right.
   assign mul_upper = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
   assign mul_next  = {mul_upper, acc[31:1]};

   // Divide: acc = {partial remainder, dividend bits / quotient bits}. The
   // remainder always fits 32 bits after the conditional subtract because it
   // is then smaller than the divisor.
   assign div_shift = {acc[63:32], acc[31]};
   assign div_ge    = (div_shift >= {1'b0, mag_b});
   assign div_rem   = div_ge ? (div_shift[31:0] - mag_b) : div_shift[31:0];
   assign div_next  = {div_rem, acc[30:0], div_ge};

   // Sign flags are only ever set for signed ops, so unsigned ops fall
   // through with no correction.
   always_comb begin
      mul_res = (sign_a ^ sign_b) ? neg64(acc) : acc;
      res_hi  = mul_res[63:32];
      res_lo  = mul_res[31:0];
      if (op_div) begin
         if (mag_b == 32'd0) begin
            res_hi = raw_a;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_lo = (sign_a ^ sign_b) ? neg32(acc[31:0]) : acc[31:0];
            res_hi = sign_a ? neg32(acc[63:32]) : acc[63:32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= 5'd0;
         op_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         raw_a  <= 32'd0;
         mag_b  <= 32'd0;
         acc    <= 64'd0;
         done   <= 1'b0;
         hi     <= 32'd0;
         lo     <= 32'd0;
      end else begin
         done <= (state == FIX);

         if (accept) begin
            count  <= 5'd0;
            op_div <= operation[1];
            sign_a <= ~operation[0] & operandA[31];
            sign_b <= ~operation[0] & operandB[31];
            raw_a  <= operandA;
            mag_b  <= mag32(operandB, ~operation[0]);
            acc    <= {32'd0, mag32(operandA, ~operation[0])};
         end else if (state == RUN) begin
            count <= count + 5'd1;
            acc   <= op_div ? div_next : mul_next;
         end

         // MT writes land on an idle edge even if start is accepted there;
         // the FIX result later overwrites them.
         if (state == FIX) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == IDLE) begin
            if (hiWrite) hi <= writeData;
            if (loWrite) lo <= writeData;
         end
      end
   end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  operation = 2'b00;
   logic [31:0] operandA = 32'd0;
   logic [31:0] operandB = 32'd0;
   logic        hiWrite = 1'b0;
   logic        loWrite = 1'b0;
   logic [31:0] writeData = 32'd0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int passed = 0;
   int total  = 0;
   logic [63:0] sb[$];

   mdu dut (
      .clk(clk), .reset(reset), .start(start), .operation(operation),
      .operandA(operandA), .operandB(operandB), .hiWrite(hiWrite),
      .loWrite(loWrite), .writeData(writeData), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Drive one start at the next rising edge, then scramble the operands to
   // show they are not re-read.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      operation = o;
      operandA  = a;
      operandB  = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      operandA = $urandom;
      operandB = $urandom;
   endtask

   // Count negedges until done; cyc = -1 if the bound expires.
   task automatic wait_done(output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         cyc++;
         if (done) return;
         if (busy) bcnt++;
      end
      cyc = -1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
      total++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
      total++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_mult;
      int cyc, bcnt;
      logic [63:0] e;
      sb.push_back({32'd0, 32'd12});
      issue(2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFD);
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc != 34) $display("FAIL mult_latency got %0d want 34", cyc); else passed++;
      total++; if (bcnt != 33) $display("FAIL mult_busy_cycles got %0d want 33", bcnt); else passed++;
      total++; if ({hi, lo} !== e) $display("FAIL mult_neg result got %h want %h", {hi, lo}, e); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL mult_done_pulse got done=%b busy=%b want 0 0", done, busy); else passed++;
   endtask

   task automatic test_multu;
      int cyc, bcnt;
      logic [63:0] e;
      sb.push_back({32'hFFFF_FFFE, 32'h0000_0001});
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc < 0 || {hi, lo} !== e) $display("FAIL multu_max got %h (cyc %0d) want %h", {hi, lo}, cyc, e); else passed++;
      sb.push_back({32'd0, 32'd1});
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc < 0 || {hi, lo} !== e) $display("FAIL mult_minus1_sq got %h (cyc %0d) want %h", {hi, lo}, cyc, e); else passed++;
   endtask

   task automatic test_div;
      int cyc, bcnt;
      logic [63:0] e;
      sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
      issue(2'b10, 32'hFFFF_FFF3, 32'd4);
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc != 34 || {hi, lo} !== e) $display("FAIL div_neg got %h (cyc %0d) want %h (cyc 34)", {hi, lo}, cyc, e); else passed++;
      sb.push_back({32'd1, 32'd3});
      issue(2'b11, 32'd13, 32'd4);
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc < 0 || {hi, lo} !== e) $display("FAIL divu got %h (cyc %0d) want %h", {hi, lo}, cyc, e); else passed++;
   endtask

   task automatic test_div_edge;
      int cyc, bcnt;
      logic [63:0] e;
      sb.push_back({32'd8, 32'hFFFF_FFFF});
      issue(2'b11, 32'd8, 32'd0);
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc != 34 || {hi, lo} !== e) $display("FAIL divu_by_zero got %h (cyc %0d) want %h (cyc 34)", {hi, lo}, cyc, e); else passed++;
      sb.push_back({32'hFFFF_FFF8, 32'hFFFF_FFFF});
      issue(2'b10, 32'hFFFF_FFF8, 32'd0);
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc < 0 || {hi, lo} !== e) $display("FAIL div_by_zero_neg got %h (cyc %0d) want %h", {hi, lo}, cyc, e); else passed++;
      sb.push_back({32'd0, 32'h8000_0000});
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc < 0 || {hi, lo} !== e) $display("FAIL div_overflow got %h (cyc %0d) want %h", {hi, lo}, cyc, e); else passed++;
   endtask

   task automatic test_mt;
      @(negedge clk);
      hiWrite = 1'b1; writeData = 32'hDEAD_BEEF;
      @(posedge clk); #1 hiWrite = 1'b0;
      @(negedge clk);
      total++; if (hi !== 32'hDEAD_BEEF) $display("FAIL mthi got %h want deadbeef", hi); else passed++;
      hiWrite = 1'b1; loWrite = 1'b1; writeData = 32'h1234_5678;
      @(posedge clk); #1 hiWrite = 1'b0; loWrite = 1'b0;
      @(negedge clk);
      total++; if ({hi, lo} !== {32'h1234_5678, 32'h1234_5678}) $display("FAIL mthi_mtlo got %h want 1234567812345678", {hi, lo}); else passed++;
   endtask

   task automatic test_ignored;
      int cyc, bcnt, extra;
      logic [63:0] e;
      sb.push_back({32'd0, 32'd35});
      issue(2'b01, 32'd5, 32'd7);
      repeat (5) @(posedge clk);
      @(negedge clk);
      loWrite = 1'b1; hiWrite = 1'b1; writeData = 32'h0000_AAAA;
      start = 1'b1; operation = 2'b01; operandA = 32'd2; operandB = 32'd2;
      @(posedge clk); #1;
      loWrite = 1'b0; hiWrite = 1'b0; start = 1'b0;
      @(negedge clk);
      total++; if ({hi, lo} !== {32'h1234_5678, 32'h1234_5678}) $display("FAIL busy_mt_ignored got %h want 1234567812345678", {hi, lo}); else passed++;
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc < 0 || {hi, lo} !== e) $display("FAIL busy_op_result got %h (cyc %0d) want %h", {hi, lo}, cyc, e); else passed++;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      total++; if (extra != 0) $display("FAIL busy_start_queued got %0d active cycles want 0", extra); else passed++;
   endtask

   task automatic test_abort;
      int cyc, bcnt, seen;
      logic [63:0] e;
      issue(2'b10, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
      total++; if ({hi, lo} !== 64'd0) $display("FAIL abort_hilo got %h want 0", {hi, lo}); else passed++;
      seen = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      total++; if (seen != 0) $display("FAIL abort_no_done got %0d pulses want 0", seen); else passed++;
      sb.push_back({32'd0, 32'd12});
      issue(2'b00, 32'd3, 32'd4);
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc != 34 || {hi, lo} !== e) $display("FAIL abort_fresh_mult got %h (cyc %0d) want %h (cyc 34)", {hi, lo}, cyc, e); else passed++;
   endtask

   task automatic test_back_to_back;
      int cyc, bcnt;
      logic [63:0] e;
      sb.push_back({32'd0, 32'd42});
      issue(2'b01, 32'd6, 32'd7);
      repeat (32) @(posedge clk);
      sb.push_back({32'd2, 32'd14});
      @(negedge clk);
      start = 1'b1; operation = 2'b11; operandA = 32'd100; operandB = 32'd7;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (done !== 1'b1 || {hi, lo} !== e) $display("FAIL b2b_first got done=%b %h want done=1 %h", done, {hi, lo}, e); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL b2b_restart_busy got %b want 1", busy); else passed++;
      wait_done(cyc, bcnt);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total++; if (cyc != 33) $display("FAIL b2b_second_latency got %0d want 33", cyc); else passed++;
      total++; if ({hi, lo} !== e) $display("FAIL b2b_second got %h want %h", {hi, lo}, e); else passed++;
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_edge();
      test_mt();
      test_ignored();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
